// File: rtl/riscv_instr_mem_responder.sv
// Instruction-fetch bus responder: grants fetch requests after optional wait states and returns
// words (plus an optional DIFT tag) from an internal memory through a fixed-latency read pipeline.
module riscv_instr_mem_responder #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned GNT_WAIT   = 0,
  parameter int unsigned RVALID_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  instr_req_i,
  input  logic [31:0]           instr_addr_i,
  output logic                  instr_gnt_o,
  output logic                  instr_rvalid_o,
  output logic [31:0]           instr_rdata_o,
`ifdef DIFT
  output logic                  instr_rdata_tag_o,
`endif
  input  logic                  stall_i,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [31:0]           wr_data_i,
  input  logic                  wr_tag_i
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  // The counter holds the wait cycles still owed after the request cycle itself,
  // so the grant lands on cycle GNT_WAIT+1 of a held request.
  localparam logic [3:0] WAIT_LOAD = (GNT_WAIT == 0) ? 4'd0 : 4'(GNT_WAIT - 1);

  typedef enum logic {S_IDLE, S_WAIT} state_e;

  state_e                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [RVALID_LAT-1:0]   vld_q, vld_d;
  logic [RVALID_LAT-1:0]   tag_q, tag_d;
  logic [31:0]             data_q [RVALID_LAT];
  logic [31:0]             data_d [RVALID_LAT];
  logic [2:0]              out_cnt_q, out_cnt_d;

  logic [31:0]             mem_q     [DEPTH];
  logic                    tag_mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0]   rd_idx;
  logic                    unused_addr_bits;

  assign rd_idx           = instr_addr_i[ADDR_WIDTH+1:2];
  assign unused_addr_bits = ^{instr_addr_i[31:ADDR_WIDTH+2], instr_addr_i[1:0]};

  // NOTE: the memory arrays are deliberately left out of the reset so they map onto RAM and
  // a reset does not wipe a loaded program.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i]     <= wr_data_i;
      tag_mem_q[wr_addr_i] <= wr_tag_i;
    end
  end

  // NOTE: every output of a combinational block gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    instr_gnt_o = 1'b0;
    if (GNT_WAIT == 0) begin
      instr_gnt_o = instr_req_i & ~stall_i;
      state_d     = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (instr_req_i) begin
            state_d = S_WAIT;
            cnt_d   = WAIT_LOAD;
          end
        end
        S_WAIT: begin
          if (!instr_req_i) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
          end else if (!stall_i) begin
            instr_gnt_o = 1'b1;
            state_d     = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Data stages only advance behind a valid, so the last stage holds the last returned word.
  always_comb begin
    vld_d     = vld_q;
    tag_d     = tag_q;
    data_d    = data_q;
    vld_d[0]  = instr_gnt_o;
    if (instr_gnt_o) begin
      data_d[0] = mem_q[rd_idx];
      tag_d[0]  = tag_mem_q[rd_idx];
    end
    for (int i = 1; i < RVALID_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      if (vld_q[i-1]) begin
        data_d[i] = data_q[i-1];
        tag_d[i]  = tag_q[i-1];
      end
    end
    out_cnt_d = out_cnt_q + 3'(instr_gnt_o) - 3'(instr_rvalid_o);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values;
  // this is also what makes a same-cycle write and read return the old word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      vld_q     <= '0;
      tag_q     <= '0;
      out_cnt_q <= '0;
      for (int i = 0; i < RVALID_LAT; i++) data_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      vld_q     <= vld_d;
      tag_q     <= tag_d;
      out_cnt_q <= out_cnt_d;
      for (int i = 0; i < RVALID_LAT; i++) data_q[i] <= data_d[i];
    end
  end

  assign instr_rvalid_o = vld_q[RVALID_LAT-1];
  assign instr_rdata_o  = data_q[RVALID_LAT-1];

`ifdef DIFT
  assign instr_rdata_tag_o = tag_q[RVALID_LAT-1];
`else
  logic unused_tag;
  assign unused_tag = tag_q[RVALID_LAT-1];
`endif

  a_gnt_needs_req: assert property (@(posedge clk) disable iff (!rst_n)
    instr_gnt_o |-> instr_req_i);

  a_addr_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (instr_req_i && !instr_gnt_o) |=> (!instr_req_i || $stable(instr_addr_i)))
    else $warning("instr_addr_i changed while request pending");

  a_rvalid_le_gnt: assert property (@(posedge clk) disable iff (!rst_n)
    instr_rvalid_o |-> (out_cnt_q != 3'd0));

endmodule

// File: tb/tb_riscv_instr_mem_responder.sv
// Scoreboard bench for riscv_instr_mem_responder: four instances cover the grant-wait and
// read-latency corners; expected words come from a bench-side memory model.
module tb_riscv_instr_mem_responder;

  localparam int N  = 4;
  localparam int AW = 12;
  localparam int unsigned GW [N] = '{0, 0, 2, 3};
  localparam int unsigned RL [N] = '{1, 3, 2, 1};

  typedef struct {
    int          inst;
    logic [31:0] data;
    logic        tag;
    int          cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  req, gnt, rvalid;
`ifdef DIFT
  logic [N-1:0]  rtag;
`endif
  logic [31:0]   addr  [N];
  logic [31:0]   rdata [N];
  logic          stall, wr_en, wr_tag;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;

  logic [31:0]   m_data [1 << AW];
  logic          m_tag  [1 << AW];
  exp_t          sb [$];
  int            cyc = 0;
  int            n_checks = 0;
  int            n_errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < N; g++) begin : g_dut
    riscv_instr_mem_responder #(
      .ADDR_WIDTH (AW),
      .GNT_WAIT   (GW[g]),
      .RVALID_LAT (RL[g])
    ) u_dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .instr_req_i       (req[g]),
      .instr_addr_i      (addr[g]),
      .instr_gnt_o       (gnt[g]),
      .instr_rvalid_o    (rvalid[g]),
      .instr_rdata_o     (rdata[g]),
`ifdef DIFT
      .instr_rdata_tag_o (rtag[g]),
`endif
      .stall_i           (stall),
      .wr_en_i           (wr_en),
      .wr_addr_i         (wr_addr),
      .wr_data_i         (wr_data),
      .wr_tag_i          (wr_tag)
    );
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Grants push the model's current word; rvalids pop and compare data and arrival cycle.
  always @(negedge clk) begin
    exp_t        e;
    int unsigned idx;
    for (int k = 0; k < N; k++) begin
      if (gnt[k]) begin
        idx    = (addr[k] >> 2) & 32'hFFF;
        e.inst = k;
        e.data = m_data[idx];
        e.tag  = m_tag[idx];
        e.cyc  = cyc + int'(RL[k]);
        sb.push_back(e);
      end
    end
    for (int k = 0; k < N; k++) begin
      if (rvalid[k]) begin
        if (sb.size() == 0) begin
          check("unexp_rvalid", 32'(rvalid[k]), 32'd0);
        end else begin
          e = sb.pop_front();
          check("rv_inst", k, e.inst);
          check("rv_cycle", cyc, e.cyc);
          check("rv_data", rdata[k], e.data);
`ifdef DIFT
          check("rv_tag", 32'(rtag[k]), 32'(e.tag));
`endif
        end
      end
    end
  end

  task automatic mem_write(input int idx, input logic [31:0] d, input logic t);
    @(posedge clk); #1;
    wr_en = 1'b1; wr_addr = AW'(idx); wr_data = d; wr_tag = t;
    @(posedge clk); #1;
    wr_en = 1'b0;
    m_data[idx] = d;
    m_tag[idx]  = t;
  endtask

  task automatic fetch(input int k, input logic [31:0] a, input int exp_n, input string tag);
    int n = 0;
    @(posedge clk); #1;
    req[k] = 1'b1; addr[k] = a;
    do begin
      @(negedge clk);
      n++;
    end while (!gnt[k] && n < 40);
    check(tag, n, exp_n);
    @(posedge clk); #1;
    req[k] = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(sb.size()), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst_n = 1'b1; req = '0; stall = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_tag = 1'b0;
    for (int k = 0; k < N; k++) addr[k] = '0;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < N; k++) begin
      check("rst_gnt", 32'(gnt[k]), 32'd0);
      check("rst_rvalid", 32'(rvalid[k]), 32'd0);
      check("rst_rdata", rdata[k], 32'd0);
    end
    rst_n = 1'b1;

    // Single fetch, then an aliased address hitting the same word.
    mem_write(16, 32'h0000_0013, 1'b0);
    fetch(0, 32'h0000_0040, 1, "t1_gnt");
    drain();
    fetch(0, 32'hABCD_0043, 1, "t1_alias_gnt");
    drain();

    // Back-to-back pipelined fetches with three in flight.
    for (int i = 0; i < 4; i++) mem_write(i, 32'hA0 + 32'(i), i[0]);
    @(posedge clk); #1;
    req[1] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      addr[1] = 32'(i * 4);
      @(negedge clk);
      check("t2_gnt", 32'(gnt[1]), 32'd1);
      @(posedge clk); #1;
    end
    req[1] = 1'b0;
    drain();

    // Grant wait states, with and without stall.
    fetch(2, 32'h8, 3, "t3_gnt");
    drain();
    @(posedge clk); #1;
    req[2] = 1'b1; addr[2] = 32'h8;
    for (int c = 1; c <= 5; c++) begin
      stall = (c >= 2 && c <= 4);
      @(negedge clk);
      check("t3_stall_gnt", 32'(gnt[2]), 32'(c == 5));
      @(posedge clk); #1;
    end
    req[2] = 1'b0; stall = 1'b0;
    drain();

    // Request abandoned during the wait, then a full wait again.
    @(posedge clk); #1;
    req[3] = 1'b1; addr[3] = 32'hC;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      check("t4_no_gnt", 32'(gnt[3]), 32'd0);
      @(posedge clk); #1;
    end
    req[3] = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("t4_idle_gnt", 32'(gnt[3]), 32'd0);
    end
    fetch(3, 32'hC, 4, "t4_full_wait");
    drain();

    // Write and granted read of the same word in one cycle: old word first, new on re-read.
    mem_write(5, 32'h1111_1111, 1'b0);
    @(posedge clk); #1;
    wr_en = 1'b1; wr_addr = AW'(5); wr_data = 32'hDEAD_BEEF; wr_tag = 1'b1;
    req[0] = 1'b1; addr[0] = 32'h14;
    @(negedge clk);
    check("t5_gnt", 32'(gnt[0]), 32'd1);
    @(posedge clk); #1;
    wr_en = 1'b0; req[0] = 1'b0;
    m_data[5] = 32'hDEAD_BEEF; m_tag[5] = 1'b1;
    drain();
    fetch(0, 32'h14, 1, "t5_regnt");
    drain();
    check("t5_hold_rvalid", 32'(rvalid[0]), 32'd0);
    check("t5_hold_rdata", rdata[0], 32'hDEAD_BEEF);

    // Reset one cycle after a grant discards the in-flight response.
    @(posedge clk); #1;
    req[2] = 1'b1; addr[2] = 32'h8;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!gnt[2] && n < 20);
    check("t6_gnt", n, 3);
    @(posedge clk); #1;
    req[2] = 1'b0;
    #1 rst_n = 1'b0;
    sb.delete();
    #1;
    for (int k = 0; k < N; k++) begin
      check("t6_rst_rvalid", 32'(rvalid[k]), 32'd0);
      check("t6_rst_rdata", rdata[k], 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    fetch(2, 32'h8, 3, "t6_post_gnt");
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
